// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction-memory write port and load status out.
interface imem_loader_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        write_enable;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_written;
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, write_enable, write_addr, write_data,
    input  cpu_hold, load_done, load_error, words_written
  );
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, write_enable, write_addr, write_data,
    output cpu_hold, load_done, load_error, words_written
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte frame into instruction memory
// as little-endian words and releases the core only after a good checksum.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input logic clk,
  input logic reset,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERR} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_len, r_widx, r_ww;
  logic [1:0]  r_bidx;
  logic [23:0] r_buf;
  logic [7:0]  r_xor;
  logic        r_we;
  logic [31:0] r_waddr, r_wdata;
  logic        w_busy, w_xfer, w_arm, w_len_bad, w_word_end, w_last;
  logic [15:0] w_len;
  assign w_busy     = r_state inside {S_LEN0, S_LEN1, S_DATA, S_CHECK};
  assign w_xfer     = bus.rx_valid && w_busy;
  assign w_arm      = bus.start && (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_len      = {bus.rx_data, r_len[7:0]};
  assign w_len_bad  = (w_len == 16'd0) || (w_len > 16'(MAX_WORDS));
  assign w_word_end = (r_state == S_DATA) && w_xfer && (r_bidx == 2'd3);
  assign w_last     = w_word_end && (r_widx == r_len - 16'd1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN0:  w_next = w_xfer ? S_LEN1 : r_state;
      S_LEN1:  w_next = w_xfer ? (w_len_bad ? S_ERR : S_DATA) : r_state;
      S_DATA:  w_next = w_last ? S_CHECK : r_state;
      S_CHECK: w_next = w_xfer ? ((bus.rx_data == r_xor) ? S_DONE : S_ERR) : r_state;
      default: w_next = w_arm ? S_LEN0 : r_state;
    endcase
  end
  // The write register fills on the 4th byte; r_we drops by itself one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len   <= '0;
      r_widx  <= '0;
      r_ww    <= '0;
      r_bidx  <= '0;
      r_buf   <= '0;
      r_xor   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_word_end;
      if (w_word_end) begin
        r_waddr <= BASE_ADDR + {14'd0, r_widx, 2'b00};
        r_wdata <= {bus.rx_data, r_buf};
        r_ww    <= r_ww + 16'd1;
        r_widx  <= r_widx + 16'd1;
      end
      if (w_xfer && r_state == S_DATA) begin
        r_bidx <= r_bidx + 2'd1;
        r_buf  <= {bus.rx_data, r_buf[23:8]};
      end
      if (w_xfer && r_state != S_CHECK) r_xor <= r_xor ^ bus.rx_data;
      if (w_xfer && r_state == S_LEN0) r_len[7:0] <= bus.rx_data;
      if (w_xfer && r_state == S_LEN1) r_len[15:8] <= bus.rx_data;
      if (w_arm) begin
        r_xor  <= '0;
        r_ww   <= '0;
        r_bidx <= '0;
        r_widx <= '0;
      end
    end
  end
  assign bus.rx_ready      = w_busy;
  assign bus.write_enable  = r_we;
  assign bus.write_addr    = r_waddr;
  assign bus.write_data    = r_wdata;
  assign bus.words_written = r_ww;
  assign bus.load_done     = r_state == S_DONE;
  assign bus.load_error    = r_state == S_ERR;
  assign bus.cpu_hold      = r_state != S_DONE;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames; expected writes go to a queue checked by a write monitor.
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  tx[$];
  logic [31:0] last_addr = '0;
  imem_loader_if bus();
  imem_loader dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      last_addr = bus.write_addr;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got=%h/%h want=none", bus.write_addr, bus.write_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", bus.write_addr, e[63:32]);
        chk("write_data", bus.write_data, e[31:0]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit gap, input bit st);
    bit ok = 1'b0;
    if (gap) begin
      bus.rx_valid = 1'b0;
      bus.start = st;
      tick();
      bus.start = 1'b0;
    end
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic r;
      r = bus.rx_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask
  task automatic run_tx(input bit gap, input int st_at);
    for (int i = 0; i < tx.size(); i++) send(tx[i], gap, i == st_at);
    bus.rx_valid = 1'b0;
  endtask
  task automatic drain(input string nm);
    tick();
    tick();
    chk(nm, exp_q.size(), 0);
  endtask
  task automatic push_good();
    exp_q.push_back({32'h0000_0000, 32'h0000_0013});
    exp_q.push_back({32'h0000_0004, 32'hDEAD_BEEF});
  endtask
  task automatic check_end(input string nm, input bit good, input logic [15:0] ww);
    chk({nm, "_done"}, bus.load_done, good);
    chk({nm, "_error"}, bus.load_error, !good);
    chk({nm, "_hold"}, bus.cpu_hold, !good);
    chk({nm, "_ready"}, bus.rx_ready, 0);
    chk({nm, "_words"}, bus.words_written, ww);
  endtask
  initial begin
    #700000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] x;
    bus.start = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    #1;
    chk("rst_ready", bus.rx_ready, 0);
    chk("rst_we", bus.write_enable, 0);
    chk("rst_addr", bus.write_addr, 0);
    chk("rst_data", bus.write_data, 0);
    chk("rst_hold", bus.cpu_hold, 1);
    chk("rst_done", bus.load_done, 0);
    chk("rst_err", bus.load_error, 0);
    chk("rst_words", bus.words_written, 0);
    tick();
    tick();
    reset = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h55;
    repeat (3) tick();
    chk("idle_ready", bus.rx_ready, 0);
    chk("idle_words", bus.words_written, 0);
    bus.rx_valid = 1'b0;
    // good frame, back-to-back
    pulse_start();
    chk("start_ready", bus.rx_ready, 1);
    push_good();
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    run_tx(1'b0, -1);
    check_end("good", 1'b1, 16'd2);
    drain("good_q");
    chk("hold_addr", bus.write_addr, 32'h4);
    chk("hold_data", bus.write_data, 32'hDEAD_BEEF);
    // bad checksum: writes still happen
    pulse_start();
    chk("rearm_done", bus.load_done, 0);
    chk("rearm_words", bus.words_written, 0);
    push_good();
    tx[10] = 8'h34;
    run_tx(1'b0, -1);
    check_end("badchk", 1'b0, 16'd2);
    drain("badchk_q");
    // N = 0
    pulse_start();
    tx = '{8'h00, 8'h00};
    run_tx(1'b0, -1);
    check_end("n0", 1'b0, 16'd0);
    drain("n0_q");
    // N = 257
    pulse_start();
    tx = '{8'h01, 8'h01};
    run_tx(1'b0, -1);
    check_end("n257", 1'b0, 16'd0);
    drain("n257_q");
    // N = 256 full frame
    pulse_start();
    tx = '{8'h00, 8'h01};
    x = 8'h01;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = {8'(i), ~8'(i), 8'(i + 3), 8'(i) ^ 8'h5A};
      exp_q.push_back({32'(i * 4), w});
      for (int j = 0; j < 4; j++) begin
        tx.push_back(w[8*j +: 8]);
        x = x ^ w[8*j +: 8];
      end
    end
    tx.push_back(x);
    run_tx(1'b0, -1);
    check_end("n256", 1'b1, 16'd256);
    drain("n256_q");
    chk("n256_last_addr", last_addr, 32'h3FC);
    // flow control with start pulsed mid-DATA
    pulse_start();
    push_good();
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    run_tx(1'b1, 5);
    check_end("flow", 1'b1, 16'd2);
    drain("flow_q");
    // async reset after 5 data bytes
    pulse_start();
    exp_q.push_back({32'h0000_0000, 32'h0000_0013});
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF};
    for (int i = 0; i < tx.size(); i++) send(tx[i], 1'b0, 1'b0);
    bus.rx_data = 8'hBE;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ready", bus.rx_ready, 0);
    chk("arst_we", bus.write_enable, 0);
    chk("arst_addr", bus.write_addr, 0);
    chk("arst_hold", bus.cpu_hold, 1);
    chk("arst_words", bus.words_written, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    bus.rx_valid = 1'b0;
    chk("arst_idle_ready", bus.rx_ready, 0);
    drain("arst_q");
    pulse_start();
    chk("recover_words0", bus.words_written, 0);
    push_good();
    tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    run_tx(1'b0, -1);
    check_end("recover", 1'b1, 16'd2);
    drain("recover_q");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
